cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter_if.sv | 43 ++++
 rtl/cdb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Bundle for the four execution-unit result ports and the common data bus broadcast.
// master = producer/consumer side (units and CDB listeners), slave = the arbiter.
interface cdb_arbiter_if;
  logic [3:0]   src_valid;
  logic [3:0]   src_ready;
  logic [127:0] src_data;
  logic [23:0]  src_tag;
  logic [3:0]   src_branch;
  logic [3:0]   src_branch_taken;
  logic [31:0]  cdb_data;
  logic [5:0]   cdb_tag;
  logic         cdb_valid;
  logic         cdb_branch;
  logic         cdb_branch_taken;

  modport master (
    output src_valid,
    output src_data,
    output src_tag,
    output src_branch,
    output src_branch_taken,
    input  src_ready,
    input  cdb_data,
    input  cdb_tag,
    input  cdb_valid,
    input  cdb_branch,
    input  cdb_branch_taken
  );

  modport slave (
    input  src_valid,
    input  src_data,
    input  src_tag,
    input  src_branch,
    input  src_branch_taken,
    output src_ready,
    output cdb_data,
    output cdb_tag,
    output cdb_valid,
    output cdb_branch,
    output cdb_branch_taken
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding slot per execution unit, one registered broadcast per cycle.
// Define CDB_ARB_RR_EN for round-robin arbitration; default is fixed div > mult > ldst > int.
module cdb_arbiter (
  input logic         clk,
  input logic         rst,
  input logic         flush,
  cdb_arbiter_if.slave bus
);

  localparam int unsigned NumSrc = 4;
  localparam int unsigned DataW  = 32;
  localparam int unsigned TagW   = 6;

  logic [NumSrc-1:0]            hold_valid_q, hold_valid_d;
  logic [NumSrc-1:0][DataW-1:0] hold_data_q, hold_data_d;
  logic [NumSrc-1:0][TagW-1:0]  hold_tag_q, hold_tag_d;
  logic [NumSrc-1:0]            hold_br_q, hold_br_d;
  logic [NumSrc-1:0]            hold_tk_q, hold_tk_d;

  logic [NumSrc-1:0] grant_raw;
  logic [NumSrc-1:0] grant;
  logic [1:0]        grant_idx;
  logic [NumSrc-1:0] ready;
  logic [NumSrc-1:0] capture;

  logic [DataW-1:0] cdb_data_q, cdb_data_d;
  logic [TagW-1:0]  cdb_tag_q, cdb_tag_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic             cdb_br_q, cdb_br_d;
  logic             cdb_tk_q, cdb_tk_d;

`ifdef CDB_ARB_RR_EN
  logic [1:0] rr_ptr_q;
  logic [1:0] rr_idx;

  // Search starts one past the last winner; k = 4 wraps back to the pointer itself.
  always_comb begin
    grant_raw = '0;
    rr_idx    = '0;
    for (int k = 1; k <= 4; k++) begin
      rr_idx = rr_ptr_q + k[1:0];
      if (grant_raw == '0 && hold_valid_q[rr_idx]) begin
        grant_raw[rr_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 2'd3;
    end else if (grant != '0) begin
      rr_ptr_q <= grant_idx;
    end
  end
`else
  // Longest-latency unit first.
  always_comb begin
    grant_raw = '0;
    if (hold_valid_q[3]) begin
      grant_raw[3] = 1'b1;
    end else if (hold_valid_q[2]) begin
      grant_raw[2] = 1'b1;
    end else if (hold_valid_q[1]) begin
      grant_raw[1] = 1'b1;
    end else if (hold_valid_q[0]) begin
      grant_raw[0] = 1'b1;
    end
  end
`endif

  // grant_raw is a function of registers only, so src_valid never reaches src_ready.
  assign grant = grant_raw & {NumSrc{~flush}};
  assign ready = {NumSrc{~flush}} & (~hold_valid_q | grant_raw);
  assign bus.src_ready = ready;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NumSrc; i++) begin
      if (grant_raw[i]) begin
        grant_idx = i[1:0];
      end
    end
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_tag_d   = hold_tag_q;
    hold_br_d    = hold_br_q;
    hold_tk_d    = hold_tk_q;
    capture      = '0;
    for (int i = 0; i < NumSrc; i++) begin
      capture[i] = bus.src_valid[i] & ready[i];
      if (flush) begin
        hold_valid_d[i] = 1'b0;
      end else if (capture[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_data_d[i]  = bus.src_data[32*i +: 32];
        hold_tag_d[i]   = bus.src_tag[6*i +: 6];
        hold_br_d[i]    = bus.src_branch[i];
        hold_tk_d[i]    = bus.src_branch_taken[i];
      end else if (grant[i]) begin
        hold_valid_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    cdb_valid_d = 1'b0;
    cdb_data_d  = '0;
    cdb_tag_d   = '0;
    cdb_br_d    = 1'b0;
    cdb_tk_d    = 1'b0;
    if (grant != '0) begin
      cdb_valid_d = 1'b1;
      cdb_data_d  = hold_data_q[grant_idx];
      cdb_tag_d   = hold_tag_q[grant_idx];
      cdb_br_d    = hold_br_q[grant_idx];
      cdb_tk_d    = hold_tk_q[grant_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= '0;
      hold_data_q  <= '0;
      hold_tag_q   <= '0;
      hold_br_q    <= '0;
      hold_tk_q    <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_tag_q   <= hold_tag_d;
      hold_br_q    <= hold_br_d;
      hold_tk_q    <= hold_tk_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_tag_q   <= '0;
      cdb_br_q    <= 1'b0;
      cdb_tk_q    <= 1'b0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_br_q    <= cdb_br_d;
      cdb_tk_q    <= cdb_tk_d;
    end
  end

  assign bus.cdb_valid        = cdb_valid_q;
  assign bus.cdb_data         = cdb_data_q;
  assign bus.cdb_tag          = cdb_tag_q;
  assign bus.cdb_branch       = cdb_br_q;
  assign bus.cdb_branch_taken = cdb_tk_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed stimulus pushes expected CDB beats (with the
// cycle they must appear in); a negedge monitor pops and compares every broadcast.
module tb_cdb_arbiter;

  logic clk;
  logic rst;
  logic flush;

  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] data;
    logic        br;
    logic        tk;
    logic [31:0] cyc;
  } beat_t;

  beat_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid beat must match the head of the scoreboard, idle beats must be zero.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cdb_valid) begin
        beat_t got;
        beat_t exp;
        got = '{tag: bus.cdb_tag, data: bus.cdb_data, br: bus.cdb_branch,
                tk: bus.cdb_branch_taken, cyc: cyc};
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL cdb_unexpected got tag=%h data=%h cycle=%0d expected no beat",
                   got.tag, got.data, cyc);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL cdb_beat got tag=%h data=%h br=%b tk=%b cyc=%0d expected tag=%h data=%h br=%b tk=%b cyc=%0d",
                     got.tag, got.data, got.br, got.tk, got.cyc,
                     exp.tag, exp.data, exp.br, exp.tk, exp.cyc);
          end
        end
      end else begin
        chk("cdb_idle_zero", {24'd0, bus.cdb_tag, bus.cdb_data, bus.cdb_branch,
                              bus.cdb_branch_taken}, 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.src_valid        = '0;
    bus.src_branch       = '0;
    bus.src_branch_taken = '0;
  endtask

  task automatic drive(input int i, input logic [5:0] tag, input logic [31:0] data,
                       input logic br, input logic tk);
    bus.src_valid[i]         = 1'b1;
    bus.src_tag[6*i +: 6]    = tag;
    bus.src_data[32*i +: 32] = data;
    bus.src_branch[i]        = br;
    bus.src_branch_taken[i]  = tk;
  endtask

  task automatic expect_beat(input logic [5:0] tag, input logic [31:0] data, input logic br,
                             input logic tk, input logic [31:0] at);
    sb.push_back('{tag: tag, data: data, br: br, tk: tk, cyc: at});
  endtask

  task automatic chk_ready(input string name, input logic [3:0] exp);
    @(negedge clk);
    chk(name, {60'd0, bus.src_ready}, {60'd0, exp});
  endtask

  logic [31:0] n;

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    bus.src_data = '0;
    bus.src_tag  = '0;
    idle();

    // Reset state
    @(negedge clk);
    chk("reset_cdb", {24'd0, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_branch,
                      bus.cdb_branch_taken}, 64'd0);
    chk("reset_ready", {60'd0, bus.src_ready}, 64'hF);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // Single result from div: visible two cycles after it is offered
    n = cyc;
    drive(3, 6'h2A, 32'hDEADBEEF, 1'b0, 1'b0);
    expect_beat(6'h2A, 32'hDEADBEEF, 1'b0, 1'b0, n + 2);
    chk_ready("single_ready_t0", 4'hF);
    tick();
    idle();
    chk_ready("single_ready_t1", 4'hF);
    tick();
    chk_ready("single_ready_t2", 4'hF);
    repeat (4) tick();

    // Four-way contention
    n = cyc;
    drive(0, 6'd1, 32'h0000_0101, 1'b0, 1'b0);
    drive(1, 6'd2, 32'h0000_0202, 1'b0, 1'b0);
    drive(2, 6'd3, 32'h0000_0303, 1'b0, 1'b0);
    drive(3, 6'd4, 32'h0000_0404, 1'b0, 1'b0);
`ifdef CDB_ARB_RR_EN
    expect_beat(6'd1, 32'h0000_0101, 1'b0, 1'b0, n + 2);
    expect_beat(6'd2, 32'h0000_0202, 1'b0, 1'b0, n + 3);
    expect_beat(6'd3, 32'h0000_0303, 1'b0, 1'b0, n + 4);
    expect_beat(6'd4, 32'h0000_0404, 1'b0, 1'b0, n + 5);
`else
    expect_beat(6'd4, 32'h0000_0404, 1'b0, 1'b0, n + 2);
    expect_beat(6'd3, 32'h0000_0303, 1'b0, 1'b0, n + 3);
    expect_beat(6'd2, 32'h0000_0202, 1'b0, 1'b0, n + 4);
    expect_beat(6'd1, 32'h0000_0101, 1'b0, 1'b0, n + 5);
`endif
    tick();
    idle();
`ifdef CDB_ARB_RR_EN
    chk_ready("cont_ready_t1", 4'b0001);
    tick();
    chk_ready("cont_ready_t2", 4'b0011);
`else
    chk_ready("cont_ready_t1", 4'b1000);
    tick();
    chk_ready("cont_ready_t2", 4'b1100);
`endif
    repeat (6) tick();

`ifndef CDB_ARB_RR_EN
    // Starvation: div streams every cycle while int waits
    n = cyc;
    drive(0, 6'h10, 32'h0000_1010, 1'b0, 1'b0);
    drive(3, 6'h20, 32'h0000_2020, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      expect_beat(6'h20 + 6'(k), 32'h0000_2020 + 32'(k), 1'b0, 1'b0, n + 2 + 32'(k));
    end
    expect_beat(6'h10, 32'h0000_1010, 1'b0, 1'b0, n + 7);
    for (int k = 1; k <= 4; k++) begin
      tick();
      bus.src_valid[0] = 1'b0;
      drive(3, 6'h20 + 6'(k), 32'h0000_2020 + 32'(k), 1'b0, 1'b0);
      @(negedge clk);
      chk("starve_ready_div_int", {62'd0, bus.src_ready[3], bus.src_ready[0]}, 64'b10);
    end
    tick();
    idle();
    @(negedge clk);
    chk("starve_ready_int_blocked", {63'd0, bus.src_ready[0]}, 64'd0);
    tick();
    @(negedge clk);
    chk("starve_ready_int_granted", {63'd0, bus.src_ready[0]}, 64'd1);
    repeat (4) tick();
`endif

    // Flush with three slots held; a new offer during flush must be ignored
    drive(0, 6'h30, 32'h0000_3030, 1'b0, 1'b0);
    drive(1, 6'h31, 32'h0000_3131, 1'b0, 1'b0);
    drive(2, 6'h32, 32'h0000_3232, 1'b0, 1'b0);
    tick();
    idle();
    flush = 1'b1;
    drive(3, 6'h33, 32'h0000_3333, 1'b0, 1'b0);
    chk_ready("flush_ready", 4'h0);
    tick();
    flush = 1'b0;
    idle();
    @(negedge clk);
    chk("flush_cdb_valid", {63'd0, bus.cdb_valid}, 64'd0);
    chk("flush_ready_after", {60'd0, bus.src_ready}, 64'hF);
    repeat (5) tick();

    // Branch pass-through followed by a non-branch beat
    n = cyc;
    drive(0, 6'h05, 32'h0000_1234, 1'b1, 1'b1);
    expect_beat(6'h05, 32'h0000_1234, 1'b1, 1'b1, n + 2);
    expect_beat(6'h06, 32'h0000_5678, 1'b0, 1'b0, n + 3);
    tick();
    drive(0, 6'h06, 32'h0000_5678, 1'b0, 1'b0);
    tick();
    idle();
    repeat (4) tick();

    // Async reset while slots are held and a beat is on the CDB
    n = cyc;
    drive(0, 6'h20, 32'h0000_4040, 1'b0, 1'b0);
    drive(1, 6'h21, 32'h0000_4141, 1'b0, 1'b0);
    drive(2, 6'h22, 32'h0000_4242, 1'b0, 1'b0);
`ifdef CDB_ARB_RR_EN
    expect_beat(6'h21, 32'h0000_4141, 1'b0, 1'b0, n + 2);
`else
    expect_beat(6'h22, 32'h0000_4242, 1'b0, 1'b0, n + 2);
`endif
    tick();
    idle();
    tick();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_cdb", {24'd0, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_branch,
                          bus.cdb_branch_taken}, 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("async_rst_ready", {60'd0, bus.src_ready}, 64'hF);
    repeat (8) tick();

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
